// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: redirect strobe, instruction-memory request/response,
// and the instruction stream handed to decode.
interface instr_fetch_unit_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        instr_ready;

  // Fetch unit side
  modport master (
    input  redirect_valid, redirect_pc,
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid, imem_resp_data,
    output instr_valid, instr_out, instr_pc,
    input  instr_ready
  );

  // Environment side: branch unit, instruction memory and decode
  modport slave (
    output redirect_valid, redirect_pc,
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid, imem_resp_data,
    input  instr_valid, instr_out, instr_pc,
    output instr_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: credit-limited sequential fetch with in-order response
// tracking, a 2-entry instruction FIFO and redirect-time squash of in-flight words.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  instr_fetch_unit_if.master  bus
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned OCC_W = 3;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] word;
  } fetch_entry_t;

  logic [XLEN-1:0]  pc_q;
  logic [XLEN-1:0]  oq_addr_q [DEPTH];
  logic             oq_rd_q;
  logic             oq_wr_q;
  logic [CNT_W-1:0] oq_cnt_q;
  fetch_entry_t     fifo_q [DEPTH];
  logic             fifo_rd_q;
  logic             fifo_wr_q;
  logic [CNT_W-1:0] fifo_cnt_q;
  logic [CNT_W-1:0] drop_q;

  logic             req_valid;
  logic             req_fire;
  logic             resp_fire;
  logic             resp_keep;
  logic             instr_valid;
  logic             instr_pop;
  logic [OCC_W-1:0] occ;
  logic             unused_redirect_lsbs;

  // A slot freed by a same-cycle decode pop is immediately reusable as credit.
  assign instr_valid = rst_n && (fifo_cnt_q != '0) && !bus.redirect_valid;
  assign instr_pop   = instr_valid && bus.instr_ready;
  assign occ         = OCC_W'(oq_cnt_q) + OCC_W'(fifo_cnt_q) - OCC_W'(instr_pop);

  assign req_valid = rst_n && !bus.redirect_valid && (occ < OCC_W'(DEPTH));
  assign req_fire  = req_valid && bus.imem_req_ready;
  assign resp_fire = bus.imem_resp_valid && (oq_cnt_q != '0);
  assign resp_keep = resp_fire && (drop_q == '0);

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc_q;
  assign bus.instr_valid    = instr_valid;
  assign bus.instr_out      = fifo_q[fifo_rd_q].word;
  assign bus.instr_pc       = fifo_q[fifo_rd_q].pc;

  assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

  // PC, outstanding-address queue, instruction FIFO and squash counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      oq_rd_q    <= 1'b0;
      oq_wr_q    <= 1'b0;
      oq_cnt_q   <= '0;
      fifo_rd_q  <= 1'b0;
      fifo_wr_q  <= 1'b0;
      fifo_cnt_q <= '0;
      drop_q     <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        oq_addr_q[i] <= '0;
        fifo_q[i]    <= '0;
      end
    end else if (bus.redirect_valid) begin
      // Every request still outstanding after this edge belongs to the old path.
      pc_q       <= {bus.redirect_pc[XLEN-1:2], 2'b00};
      fifo_rd_q  <= 1'b0;
      fifo_wr_q  <= 1'b0;
      fifo_cnt_q <= '0;
      if (resp_fire) begin
        oq_rd_q  <= ~oq_rd_q;
        oq_cnt_q <= oq_cnt_q - CNT_W'(1);
        drop_q   <= oq_cnt_q - CNT_W'(1);
      end else begin
        drop_q   <= oq_cnt_q;
      end
    end else begin
      if (req_fire) begin
        pc_q               <= pc_q + XLEN'(4);
        oq_addr_q[oq_wr_q] <= pc_q;
        oq_wr_q            <= ~oq_wr_q;
      end
      if (resp_fire) begin
        oq_rd_q <= ~oq_rd_q;
        if (drop_q != '0) begin
          drop_q <= drop_q - CNT_W'(1);
        end
      end
      oq_cnt_q <= oq_cnt_q + CNT_W'(req_fire) - CNT_W'(resp_fire);

      if (resp_keep) begin
        fifo_q[fifo_wr_q] <= '{pc: oq_addr_q[oq_rd_q], word: bus.imem_resp_data};
        fifo_wr_q         <= ~fifo_wr_q;
      end
      if (instr_pop) begin
        fifo_rd_q <= ~fifo_rd_q;
      end
      fifo_cnt_q <= fifo_cnt_q + CNT_W'(resp_keep) - CNT_W'(instr_pop);
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: in-order memory model with adjustable
// latency, expected-PC scoreboard drained by an independent delivery monitor.
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0080;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } mreq_t;

  logic        clk = 1'b0;
  logic        rst_n;
  int unsigned cyc = 0;
  int unsigned lat = 1;
  int          n_checks = 0;
  int          n_pass = 0;

  mreq_t       mem_q[$];
  logic [31:0] exp_q[$];

  instr_fetch_unit_if bus();

  instr_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
  endfunction

  // Memory: record accepted requests; reset wipes anything in flight.
  always @(negedge clk) begin
    if (!rst_n) mem_q.delete();
    else if (bus.imem_req_valid && bus.imem_req_ready)
      mem_q.push_back('{addr: bus.imem_req_addr, due: cyc + lat});
  end

  // Memory: return responses in order once their latency has elapsed.
  always @(posedge clk) begin
    mreq_t m;
    #2;
    if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      m = mem_q.pop_front();
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = mem_word(m.addr);
    end else begin
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = 32'h0;
    end
  end

  // Monitor: every delivered instruction must match the scoreboard head.
  always @(negedge clk) begin
    logic [31:0] e;
    #1;
    if (bus.instr_valid && bus.instr_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_instr: got pc 0x%08h, expected no delivery", bus.instr_pc);
      end else begin
        e = exp_q.pop_front();
        chk("instr_pc", bus.instr_pc, e);
        chk("instr_out", bus.instr_out, mem_word(e));
      end
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(string name, int budget, output int used);
    used = 0;
    while (exp_q.size() != 0 && used < budget) begin
      tick(1);
      used++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic push_seq(logic [31:0] start, int n);
    for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int used;
    rst_n               = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = 32'h0;
    bus.imem_req_ready  = 1'b1;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = 32'h0;
    bus.instr_ready     = 1'b1;

    // Reset and streaming at latency 1
    tick(3);
    chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
    push_seq(32'h80, 8);
    rst_n = 1'b1;
    #1;
    chk("first_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("first_req_addr", bus.imem_req_addr, RST_PC);
    drain("stream_drain", 40, used);
    chk("stream_cycles", 32'(used), 32'd10);

    // Decode stalled: credits run out with two words buffered
    bus.instr_ready = 1'b0;
    tick(3);
    chk("stall_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("stall_instr_valid", 32'(bus.instr_valid), 32'd1);
    chk("stall_head_pc", bus.instr_pc, 32'hA0);
    tick(2);
    chk("stall_req_valid_hold", 32'(bus.imem_req_valid), 32'd0);
    push_seq(32'hA0, 4);
    bus.instr_ready = 1'b1;
    drain("resume_drain", 20, used);
    bus.instr_ready = 1'b0;
    tick(4);

    // Redirect near the top of the address space, PC wraps
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFF8;
    #1;
    chk("redir_instr_valid", 32'(bus.instr_valid), 32'd0);
    chk("redir_req_valid", 32'(bus.imem_req_valid), 32'd0);
    tick(1);
    bus.redirect_valid = 1'b0;
    #1;
    chk("wrap_req_addr", bus.imem_req_addr, 32'hFFFF_FFF8);
    exp_q.push_back(32'hFFFF_FFF8);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0000_0000);
    exp_q.push_back(32'h0000_0004);
    bus.instr_ready = 1'b1;
    drain("wrap_drain", 30, used);
    bus.instr_ready = 1'b0;
    tick(4);

    // Memory back-pressure: address held until accepted
    bus.imem_req_ready = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0200;
    tick(1);
    bus.redirect_valid = 1'b0;
    #1;
    chk("bp_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("bp_req_addr", bus.imem_req_addr, 32'h200);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("bp_addr_hold", bus.imem_req_addr, 32'h200);
      chk("bp_valid_hold", 32'(bus.imem_req_valid), 32'd1);
    end
    bus.imem_req_ready = 1'b1;
    push_seq(32'h200, 2);
    bus.instr_ready = 1'b1;
    drain("bp_drain", 30, used);
    bus.instr_ready = 1'b0;
    tick(4);

    // Two in flight, back-to-back redirects; the first response lands with the second
    lat = 3;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0300;
    tick(1);
    bus.redirect_valid = 1'b0;
    tick(2);
    chk("inflight_req_valid", 32'(bus.imem_req_valid), 32'd0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0500;
    tick(1);
    bus.redirect_pc    = 32'h0000_0103;
    tick(1);
    bus.redirect_valid = 1'b0;
    #1;
    chk("squash_req_addr", bus.imem_req_addr, 32'h100);
    chk("squash_instr_valid", 32'(bus.instr_valid), 32'd0);
    push_seq(32'h100, 2);
    bus.instr_ready = 1'b1;
    drain("squash_drain", 40, used);
    bus.instr_ready = 1'b0;
    tick(6);
    lat = 1;

    // Reset pulse mid-stream
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0400;
    tick(1);
    bus.redirect_valid = 1'b0;
    push_seq(32'h400, 2);
    push_seq(32'h80, 4);
    bus.instr_ready = 1'b1;
    tick(4);
    rst_n = 1'b0;
    #1;
    chk("midrst_instr_valid", 32'(bus.instr_valid), 32'd0);
    chk("midrst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    tick(1);
    rst_n = 1'b1;
    #1;
    chk("postrst_instr_valid", 32'(bus.instr_valid), 32'd0);
    chk("postrst_req_addr", bus.imem_req_addr, RST_PC);
    drain("postrst_drain", 40, used);
    bus.instr_ready = 1'b0;
    tick(5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h00000000, meaning the PC loaded on reset (bits[1:0] must be 0).
REQ-002 The block SHALL have port CLK  input  1  rising-edge clock for all state.
REQ-003 The block SHALL have port RST_N  input  1  reset, synchronous, active-low.
REQ-004 The block SHALL have port REDIRECT_VALID  input  1  branch/jump redirect strobe.
REQ-005 The block SHALL have port REDIRECT_PC  input  32  redirect target address.
REQ-006 The block SHALL have port IMEM_REQ_VALID  output  1  fetch request valid.
REQ-007 The block SHALL have port IMEM_REQ_ADDR  output  32  fetch address, equal to current PC.
REQ-008 The block SHALL have port IMEM_REQ_READY  input  1  memory accepts request.
REQ-009 The block SHALL have port IMEM_RESP_VALID  input  1  one-cycle read-data strobe, in request order.
REQ-010 The block SHALL have port IMEM_RESP_DATA  input  32  fetched instruction word.
REQ-011 The block SHALL have port INSTR_VALID  output  1  instruction available to decode.
REQ-012 The block SHALL have port INSTR_OUT  output  32  instruction word at FIFO head.
REQ-013 The block SHALL have port INSTR_PC  output  32  address of INSTR_OUT.
REQ-014 The block SHALL have port INSTR_READY  input  1  decode consumes instruction.

Function
REQ-015 The block SHALL hold a 32-bit PC register, a 2-entry outstanding-address queue, a 2-entry instruction FIFO of {PC, word}, and a 2-bit drop counter.
REQ-016 The block SHALL assert IMEM_REQ_VALID iff RST_N=1, REDIRECT_VALID=0, and outstanding+FIFO occupancy < 2 (credit rule; the FIFO never overflows).
REQ-017 A request SHALL be accepted on IMEM_REQ_VALID&&IMEM_REQ_READY; on acceptance, PC <= PC+4 modulo 2^32 (32'hFFFFFFFC wraps to 32'h00000000) and the address is pushed onto the outstanding queue.
REQ-018 While a request is pending and unaccepted with no redirect, IMEM_REQ_ADDR SHALL remain stable.
REQ-019 The memory response SHALL have latency >=1 cycle after acceptance; each IMEM_RESP_VALID pops the outstanding queue.
REQ-020 On a response with drop counter = 0, the block SHALL push {popped address, IMEM_RESP_DATA} into the FIFO; with drop counter > 0, it SHALL discard the word and decrement the counter.
REQ-021 INSTR_VALID SHALL equal (FIFO non-empty && REDIRECT_VALID=0); INSTR_OUT/INSTR_PC SHALL show the FIFO head; a pop SHALL occur on INSTR_VALID&&INSTR_READY.
REQ-022 Push and pop in the same cycle SHALL both take effect, leaving occupancy unchanged.
REQ-023 On REDIRECT_VALID=1, the next edge SHALL set PC <= {REDIRECT_PC[31:2],2'b00}, flush the FIFO, and set the drop counter to outstanding requests remaining after any same-cycle response is accounted for; no request is accepted and no instruction is popped that cycle.
REQ-024 A pending unaccepted request SHALL be withdrawn on redirect (permitted by this memory interface).
REQ-025 Back-to-back redirects SHALL each apply; the last one determines PC, and drop counts SHALL accumulate correctly (never exceeding 2).
REQ-026 Instructions SHALL be delivered in strictly increasing PC order (+4) between redirects, with no duplicates or gaps.

Reset
REQ-027 While RST_N=0 at a rising edge, the block SHALL set PC=RESET_PC, outstanding=0, FIFO empty, and drop counter=0.
REQ-028 During reset, IMEM_REQ_VALID and INSTR_VALID SHALL be 0; the first request (addr RESET_PC) SHALL assert in the first cycle after RST_N rises.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight and buffered state; responses arriving during reset SHALL be ignored.

Verification
REQ-030 Reset release, memory READY=1, latency 1, INSTR_READY=1 -> INSTR_PC sequence 0x0,0x4,0x8,... with matching data, one per cycle in steady state.
REQ-031 INSTR_READY=0 held -> exactly 2 requests issued (0x0,0x4), then IMEM_REQ_VALID=0 until a pop; no FIFO data lost.
REQ-032 PC=32'hFFFFFFF8 via redirect -> fetches 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000 in order.
REQ-033 Redirect to 32'h00000103 with 2 requests in flight -> both responses dropped, next INSTR_PC=0x00000100, FIFO flushed.
REQ-034 IMEM_REQ_READY=0 for 3 cycles -> IMEM_REQ_ADDR held constant, PC unchanged until acceptance.
REQ-035 RST_N=0 pulsed for 1 cycle mid-stream with RESET_PC=32'h00000080 -> INSTR_VALID=0 next cycle, fetch restarts at 0x80, no stale instruction delivered.
